// File: rtl/mma_pkg.sv
// Shared constants, FSM state encoding and dimension check for the MMA
// command/packet receiver.
package mma_pkg;

    localparam logic [7:0] CMD_RX_A     = 8'h01;
    localparam logic [7:0] CMD_RX_B     = 8'h02;
    localparam logic [7:0] CMD_MULTIPLY = 8'h03;
    localparam logic [7:0] CMD_TX_R     = 8'h04;
    localparam logic [7:0] CMD_ACK      = 8'h06;
    localparam logic [7:0] CMD_ERR      = 8'hAA;

    localparam int MAX_DIM_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_ROWS,
        S_HDR_COLS,
        S_DATA,
        S_SEND_ACK,
        S_SEND_ERR
    } state_t;

    // The full 32-bit header word is checked so that junk in the upper bytes is rejected.
    function automatic logic dim_ok(input logic [31:0] v, input int unsigned max_dim);
        return (v != 32'd0) && (v <= max_dim);
    endfunction

endpackage

// File: rtl/mma_matrix_rx_if.sv
// Byte-stream, transmit, matrix-storage and control signals of the MMA receiver.
// The slave modport is the receiver itself; master is the surrounding system.
interface mma_matrix_rx_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              rx_error;
    logic [7:0]        tx_data;
    logic              tx_begin;
    logic              tx_busy;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [7:0]        rows_a;
    logic [7:0]        cols_a;
    logic [7:0]        rows_b;
    logic [7:0]        cols_b;
    logic              a_valid;
    logic              b_valid;
    logic              cmd_multiply;
    logic              cmd_tx_result;
    logic              busy;

    modport slave (
        input  rx_data, rx_ready, rx_error, tx_busy,
        output tx_data, tx_begin, mem_we, mem_sel, mem_addr, mem_wdata,
               rows_a, cols_a, rows_b, cols_b, a_valid, b_valid,
               cmd_multiply, cmd_tx_result, busy
    );

    modport master (
        output rx_data, rx_ready, rx_error, tx_busy,
        input  tx_data, tx_begin, mem_we, mem_sel, mem_addr, mem_wdata,
               rows_a, cols_a, rows_b, cols_b, a_valid, b_valid,
               cmd_multiply, cmd_tx_result, busy
    );
endinterface

// File: rtl/mma_word_assembler.sv
// Packs four bytes, MSB first, into a big-endian word; word_valid_o is
// combinational and coincides with the fourth accepted byte.
module mma_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {shift_q[15:0], byte_i};
        end
    end

    assign word_valid_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o       = {shift_q, byte_i};

endmodule

// File: rtl/mma_matrix_rx.sv
// Command parser of the MMA: decodes host commands, loads matrix A/B elements
// into storage and answers each load with an ACK or ERR byte.
module mma_matrix_rx
    import mma_pkg::*;
#(
    parameter int MAX_DIM        = MAX_DIM_DEF,
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic          clk,
    input logic          reset,
    mma_matrix_rx_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic [31:0]       rows_hdr_q, rows_hdr_d;
    logic [7:0]        rows_a_q, rows_a_d, cols_a_q, cols_a_d;
    logic [7:0]        rows_b_q, rows_b_d, cols_b_q, cols_b_d;
    logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
    logic [ADDR_W-1:0] elem_q, elem_d, last_q, last_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_begin_q, tx_begin_d;
    logic              cmd_mul_q, cmd_mul_d, cmd_txr_q, cmd_txr_d;

    logic              in_pkt, abort, asm_valid, word_valid;
    logic [31:0]       word;
    logic [15:0]       n_elem;

    assign in_pkt    = state_q inside {S_HDR_ROWS, S_HDR_COLS, S_DATA};
    assign abort     = in_pkt && (bus.rx_error || (tmo_q == TMO_W'(TIMEOUT_CYCLES)));
    // A byte flagged with a framing error is never assembled.
    assign asm_valid = in_pkt && bus.rx_ready && !bus.rx_error;
    assign n_elem    = 16'(rows_hdr_q[7:0]) * 16'(word[7:0]);

    mma_word_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (abort),
        .byte_valid_i (asm_valid),
        .byte_i       (bus.rx_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rows_hdr_d  = rows_hdr_q;
        rows_a_d    = rows_a_q;
        cols_a_d    = cols_a_q;
        rows_b_d    = rows_b_q;
        cols_b_d    = cols_b_q;
        a_valid_d   = a_valid_q;
        b_valid_d   = b_valid_q;
        elem_d      = elem_q;
        last_d      = last_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        tx_data_d   = tx_data_q;
        mem_we_d    = 1'b0;
        tx_begin_d  = 1'b0;
        cmd_mul_d   = 1'b0;
        cmd_txr_d   = 1'b0;
        tmo_d       = (in_pkt && !bus.rx_ready) ? tmo_q + 1'b1 : '0;

        case (state_q)
            S_IDLE: if (bus.rx_ready) begin
                case (bus.rx_data)
                    CMD_RX_A: begin sel_d = 1'b0; a_valid_d = 1'b0; state_d = S_HDR_ROWS; end
                    CMD_RX_B: begin sel_d = 1'b1; b_valid_d = 1'b0; state_d = S_HDR_ROWS; end
                    CMD_MULTIPLY:
                        if (a_valid_q && b_valid_q && (cols_a_q == rows_b_q)) cmd_mul_d = 1'b1;
                        else state_d = S_SEND_ERR;
                    CMD_TX_R: cmd_txr_d = 1'b1;
                    default:  state_d = S_SEND_ERR;
                endcase
            end
            S_HDR_ROWS:
                if (abort) state_d = S_SEND_ERR;
                else if (word_valid) begin
                    rows_hdr_d = word;
                    state_d    = S_HDR_COLS;
                end
            S_HDR_COLS:
                if (abort) state_d = S_SEND_ERR;
                else if (word_valid) begin
                    if (!dim_ok(rows_hdr_q, MAX_DIM) || !dim_ok(word, MAX_DIM)) begin
                        state_d = S_SEND_ERR;
                    end else begin
                        if (sel_q) begin rows_b_d = rows_hdr_q[7:0]; cols_b_d = word[7:0]; end
                        else       begin rows_a_d = rows_hdr_q[7:0]; cols_a_d = word[7:0]; end
                        last_d  = ADDR_W'(n_elem - 16'd1);
                        elem_d  = '0;
                        state_d = S_DATA;
                    end
                end
            S_DATA:
                if (abort) state_d = S_SEND_ERR;
                else if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = elem_q;
                    mem_wdata_d = word;
                    elem_d      = elem_q + 1'b1;
                    // Valid rises on the same edge that presents the final write.
                    if (elem_q == last_q) begin
                        if (sel_q) b_valid_d = 1'b1;
                        else       a_valid_d = 1'b1;
                        state_d = S_SEND_ACK;
                    end
                end
            S_SEND_ACK:
                if (!bus.tx_busy) begin
                    tx_data_d = CMD_ACK; tx_begin_d = 1'b1; state_d = S_IDLE;
                end
            S_SEND_ERR:
                if (!bus.tx_busy) begin
                    tx_data_d = CMD_ERR; tx_begin_d = 1'b1; state_d = S_IDLE;
                end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 1'b0;
            rows_hdr_q  <= '0;
            rows_a_q    <= '0;
            cols_a_q    <= '0;
            rows_b_q    <= '0;
            cols_b_q    <= '0;
            a_valid_q   <= 1'b0;
            b_valid_q   <= 1'b0;
            elem_q      <= '0;
            last_q      <= '0;
            tmo_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tx_data_q   <= '0;
            tx_begin_q  <= 1'b0;
            cmd_mul_q   <= 1'b0;
            cmd_txr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rows_hdr_q  <= rows_hdr_d;
            rows_a_q    <= rows_a_d;
            cols_a_q    <= cols_a_d;
            rows_b_q    <= rows_b_d;
            cols_b_q    <= cols_b_d;
            a_valid_q   <= a_valid_d;
            b_valid_q   <= b_valid_d;
            elem_q      <= elem_d;
            last_q      <= last_d;
            tmo_q       <= tmo_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tx_data_q   <= tx_data_d;
            tx_begin_q  <= tx_begin_d;
            cmd_mul_q   <= cmd_mul_d;
            cmd_txr_q   <= cmd_txr_d;
        end
    end

    assign bus.tx_data       = tx_data_q;
    assign bus.tx_begin      = tx_begin_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_sel       = sel_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.rows_a        = rows_a_q;
    assign bus.cols_a        = cols_a_q;
    assign bus.rows_b        = rows_b_q;
    assign bus.cols_b        = cols_b_q;
    assign bus.a_valid       = a_valid_q;
    assign bus.b_valid       = b_valid_q;
    assign bus.cmd_multiply  = cmd_mul_q;
    assign bus.cmd_tx_result = cmd_txr_q;
    assign bus.busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mma_matrix_rx.sv
// Bench for mma_matrix_rx: directed vector table, multi-cycle corner sequences,
// then randomized packets scored against a matrix-level model.
module tb_mma_matrix_rx;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mma_matrix_rx_if #(.ADDR_W(8)) bus ();

    mma_matrix_rx #(.MAX_DIM(16), .ADDR_W(8), .TIMEOUT_CYCLES(100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic        sel;
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    typedef struct packed {
        logic [7:0]  cmd;
        logic [31:0] rows;
        logic [31:0] cols;
        logic [7:0]  nd;
        logic [7:0]  dbase;
        logic [7:0]  rsp;
        logic [7:0]  nwr;
        logic        mul;
        logic        txr;
        logic        av;
        logic        bv;
    } vec_t;

    wr_t         wr_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] exp_w[$];
    int          mul_cnt, txr_cnt;
    int          checks = 0, errors = 0;
    int          gap_max = 0;
    logic [31:0] fl [8];
    vec_t        tbl [14];

    // Output monitor
    always @(negedge clk) begin
        if (bus.mem_we)        wr_q.push_back('{bus.mem_sel, bus.mem_addr, bus.mem_wdata});
        if (bus.tx_begin)      tx_q.push_back(bus.tx_data);
        if (bus.cmd_multiply)  mul_cnt++;
        if (bus.cmd_tx_result) txr_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic err);
        bus.rx_data  = b;
        bus.rx_ready = 1'b1;
        bus.rx_error = err;
        tick();
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
        repeat ($urandom_range(gap_max, 0)) tick();
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
    endtask

    task automatic clr_mon();
        wr_q.delete();
        tx_q.delete();
        exp_w.delete();
        mul_cnt = 0;
        txr_cnt = 0;
    endtask

    task automatic chk_writes(input string nm, input logic sel);
        chk({nm, "_count"}, 64'(wr_q.size()), 64'(exp_w.size()));
        for (int i = 0; i < wr_q.size() && i < exp_w.size(); i++)
            chk({nm, "_word"}, {wr_q[i].sel, wr_q[i].addr, wr_q[i].data}, {sel, 8'(i), exp_w[i]});
    endtask

    task automatic chk_rsp(input string nm, input logic [7:0] rsp);
        chk({nm, "_rsp_count"}, 64'(tx_q.size()), (rsp == 8'h00) ? 64'd0 : 64'd1);
        if (tx_q.size() > 0 && rsp != 8'h00) chk({nm, "_rsp_byte"}, tx_q[0], rsp);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {bus.mem_we, bus.mem_sel, bus.mem_addr, bus.mem_wdata, bus.tx_data,
                           bus.tx_begin, bus.a_valid, bus.b_valid, bus.cmd_multiply,
                           bus.cmd_tx_result, bus.busy}, 64'd0);
        chk({nm, "_dims"}, {bus.rows_a, bus.cols_a, bus.rows_b, bus.cols_b}, 64'd0);
    endtask

    task automatic run_vec(input int v);
        vec_t t;
        t = tbl[v];
        clr_mon();
        send_byte(t.cmd, 1'b0);
        if (t.cmd == 8'h01 || t.cmd == 8'h02) begin
            send_word(t.rows);
            send_word(t.cols);
            for (int i = 0; i < int'(t.nd); i++) send_word(fl[int'(t.dbase) + i]);
        end
        for (int i = 0; i < int'(t.nwr); i++) exp_w.push_back(fl[int'(t.dbase) + i]);
        repeat (20) tick();
        chk_writes($sformatf("vec%0d", v), t.cmd == 8'h02);
        chk_rsp($sformatf("vec%0d", v), t.rsp);
        chk($sformatf("vec%0d_pulses", v), {32'(mul_cnt), 32'(txr_cnt)}, {32'(t.mul), 32'(t.txr)});
        chk($sformatf("vec%0d_valid", v), {bus.a_valid, bus.b_valid}, {t.av, t.bv});
        if (t.rsp == 8'h06 && t.cmd == 8'h01)
            chk($sformatf("vec%0d_dims_a", v), {bus.rows_a, bus.cols_a}, {t.rows[7:0], t.cols[7:0]});
        if (t.rsp == 8'h06 && t.cmd == 8'h02)
            chk($sformatf("vec%0d_dims_b", v), {bus.rows_b, bus.cols_b}, {t.rows[7:0], t.cols[7:0]});
    endtask

    // Matrix-level model state for the random phase
    logic       m_av, m_bv;
    logic [7:0] m_ra, m_ca, m_rb, m_cb;

    initial begin
        fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
        //         cmd    rows   cols   nd    dbase rsp    nwr   mul   txr   av    bv
        tbl[0]  = '{8'h01, 32'd2,  32'd2, 8'd4, 8'd0, 8'h06, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1]  = '{8'h02, 32'd2,  32'd2, 8'd4, 8'd4, 8'h06, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[2]  = '{8'h03, 32'd0,  32'd0, 8'd0, 8'd0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{8'h04, 32'd0,  32'd0, 8'd0, 8'd0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[4]  = '{8'h55, 32'd0,  32'd0, 8'd0, 8'd0, 8'hAA, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{8'h01, 32'd2,  32'd3, 8'd6, 8'd0, 8'h06, 8'd6, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[6]  = '{8'h03, 32'd0,  32'd0, 8'd0, 8'd0, 8'hAA, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[7]  = '{8'h01, 32'd17, 32'd2, 8'd0, 8'd0, 8'hAA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{8'h03, 32'd0,  32'd0, 8'd0, 8'd0, 8'hAA, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{8'h01, 32'd2,  32'd2, 8'd4, 8'd0, 8'h06, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[10] = '{8'h02, 32'd0,  32'd2, 8'd0, 8'd0, 8'hAA, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{8'h03, 32'd0,  32'd0, 8'd0, 8'd0, 8'hAA, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{8'h02, 32'd2,  32'd2, 8'd4, 8'd4, 8'h06, 8'd4, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{8'h03, 32'd0,  32'd0, 8'd0, 8'd0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b1, 1'b1};

        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_ready = 1'b0;
        bus.rx_error = 1'b0;
        bus.tx_busy  = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        for (int v = 0; v < 14; v++) run_vec(v);

        // cmd_multiply exactly one cycle after the 03 byte, single pulse
        bus.rx_data = 8'h03; bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        chk("mul_lat_hi", bus.cmd_multiply, 1'b1);
        tick();
        chk("mul_lat_lo", bus.cmd_multiply, 1'b0);
        repeat (5) tick();

        // rx_error while idle is ignored
        clr_mon();
        bus.rx_error = 1'b1;
        tick();
        bus.rx_error = 1'b0;
        repeat (10) tick();
        chk("idle_err_rsp", 64'(tx_q.size()), 64'd0);
        chk("idle_err_busy", bus.busy, 1'b0);

        // rx_error coinciding with rx_ready aborts and drops the byte
        clr_mon();
        send_byte(8'h01, 1'b0);
        send_word(32'd2);
        send_word(32'd2);
        send_byte(8'h3F, 1'b0);
        send_byte(8'h80, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (20) tick();
        chk_writes("rxerr", 1'b0);
        chk_rsp("rxerr", 8'hAA);
        chk("rxerr_avalid", bus.a_valid, 1'b0);

        // Timeout mid-DATA: one element written, then ERR
        clr_mon();
        send_byte(8'h01, 1'b0);
        send_word(32'd2);
        send_word(32'd2);
        for (int i = 3; i >= 1; i--) send_byte(fl[0][8*i +: 8], 1'b0);
        bus.rx_data = fl[0][7:0]; bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        chk("we_lat", {bus.mem_we, bus.mem_addr}, {1'b1, 8'd0});
        send_byte(8'h40, 1'b0);
        repeat (60) tick();
        chk("tmo_early", 64'(tx_q.size()), 64'd0);
        repeat (90) tick();
        exp_w.push_back(fl[0]);
        chk_writes("tmo", 1'b0);
        chk_rsp("tmo", 8'hAA);
        chk("tmo_avalid", bus.a_valid, 1'b0);
        clr_mon();
        send_byte(8'h04, 1'b0);
        repeat (5) tick();
        chk("tmo_txr", {32'(txr_cnt), 32'(tx_q.size())}, {32'd1, 32'd0});

        // Reset in the middle of DATA
        clr_mon();
        send_byte(8'h01, 1'b0);
        send_word(32'd2);
        send_word(32'd2);
        send_word(fl[1]);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        reset = 1'b1;
        tick();
        chk_all_zero("reset_mid");
        reset = 1'b0;
        clr_mon();
        repeat (200) tick();
        chk("reset_no_err", 64'(tx_q.size()), 64'd0);
        run_vec(0);

        // Randomized phase against the model
        m_av = 1'b1; m_ra = 8'd2; m_ca = 8'd2;
        m_bv = 1'b0; m_rb = 8'd0; m_cb = 8'd0;
        gap_max = 3;
        for (int it = 0; it < 30; it++) begin
            int          op;
            logic        hold;
            logic [7:0]  rsp;
            logic        emul, etxr, sel;
            op   = $urandom_range(9, 0);
            hold = ($urandom_range(3, 0) == 0);
            rsp  = 8'h00; emul = 1'b0; etxr = 1'b0; sel = 1'b0;
            clr_mon();
            bus.tx_busy = hold;
            if (op <= 5) begin
                int          r, c;
                logic        bad;
                logic [31:0] rw, cw, badv;
                sel  = 1'($urandom_range(1, 0));
                r    = $urandom_range(4, 1);
                c    = $urandom_range(4, 1);
                bad  = ($urandom_range(4, 0) == 0);
                badv = ($urandom_range(1, 0) == 1) ? 32'd0 : 32'($urandom_range(300, 17));
                rw   = 32'(r);
                cw   = 32'(c);
                if (bad) begin
                    if ($urandom_range(1, 0) == 1) rw = badv;
                    else cw = badv;
                end
                send_byte(sel ? 8'h02 : 8'h01, 1'b0);
                send_word(rw);
                send_word(cw);
                if (sel) m_bv = 1'b0; else m_av = 1'b0;
                if (bad) begin
                    rsp = 8'hAA;
                end else begin
                    for (int k = 0; k < r * c; k++) begin
                        logic [31:0] w;
                        w = $urandom;
                        exp_w.push_back(w);
                        send_word(w);
                    end
                    rsp = 8'h06;
                    if (sel) begin m_bv = 1'b1; m_rb = 8'(r); m_cb = 8'(c); end
                    else     begin m_av = 1'b1; m_ra = 8'(r); m_ca = 8'(c); end
                end
            end else if (op <= 7) begin
                send_byte(8'h03, 1'b0);
                emul = m_av && m_bv && (m_ca == m_rb);
                rsp  = emul ? 8'h00 : 8'hAA;
            end else if (op == 8) begin
                send_byte(8'h04, 1'b0);
                etxr = 1'b1;
            end else begin
                logic [7:0] junk [5];
                junk = '{8'h00, 8'h05, 8'h06, 8'hAA, 8'hFF};
                send_byte(junk[$urandom_range(4, 0)], 1'b0);
                rsp = 8'hAA;
            end
            if (hold) begin
                repeat (10) tick();
                chk("rnd_busy_hold", 64'(tx_q.size()), 64'd0);
                bus.tx_busy = 1'b0;
            end
            repeat (20) tick();
            chk_writes("rnd", sel);
            chk_rsp("rnd", rsp);
            chk("rnd_pulses", {32'(mul_cnt), 32'(txr_cnt)}, {32'(emul), 32'(etxr)});
            chk("rnd_valid", {bus.a_valid, bus.b_valid}, {m_av, m_bv});
            chk("rnd_dims", {bus.rows_a, bus.cols_a, bus.rows_b, bus.cols_b}, {m_ra, m_ca, m_rb, m_cb});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mma_matrix_rx.md
Name: mma_matrix_rx

Overview:
- Command/packet front end of the matrix multiplication accelerator (MMA).
- Sits directly downstream of the UART receiver and upstream of the matrix buffers and multiply engine.
- Parses host command bytes and assembles big-endian 32-bit words from the byte stream. Validates matrix dimensions, writes elements into matrix A/B storage, and issues ACK/ERR bytes to the UART transmitter.
- Raises start pulses for multiplication and result return.

Parameters:
- MAX_DIM, 16, largest allowed row/column count
- ADDR_W, 8, element address width; must satisfy 2^ADDR_W >= MAX_DIM*MAX_DIM
- TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes inside a packet before abort

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- rx_data  in  8  received UART byte
- rx_ready  in  1  one-cycle pulse, rx_data valid
- rx_error  in  1  one-cycle pulse, framing error on current byte
- tx_data  out  8  byte to transmit
- tx_begin  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy
- mem_we  out  1  element write strobe
- mem_sel  out  1  0 = matrix A, 1 = matrix B
- mem_addr  out  ADDR_W  row-major element index
- mem_wdata  out  32  element word
- rows_a, cols_a, rows_b, cols_b  out  8 each  latched dimensions
- a_valid, b_valid  out  1 each  matrix fully loaded
- cmd_multiply  out  1  one-cycle start pulse to multiply engine
- cmd_tx_result  out  1  one-cycle pulse to result transmitter
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0, dimensions 0, a_valid and b_valid 0, state IDLE. Reset mid-packet discards the partial packet; no ERR is sent.
- Command codes: 0x01 RX_A, 0x02 RX_B, 0x03 MULTIPLY, 0x04 TX_R, 0x06 ACK, 0xAA ERR.
- IDLE:
  - 0x01 or 0x02: latch mem_sel, clear the target's valid flag, go to HDR_ROWS.
  - 0x03: if a_valid && b_valid && cols_a == rows_b, pulse cmd_multiply the next cycle; otherwise go to SEND_ERR.
  - 0x04: pulse cmd_tx_result.
  - Any other byte: SEND_ERR.
- Word assembly:
  - A 2-bit byte counter fills bytes MSB first.
  - The word completes on the 4th rx_ready.
  - The counter wraps to 0 after each word.
- HDR_ROWS and HDR_COLS:
  - Each state takes one 32-bit word.
  - Out of HDR_COLS: if either value is 0 or greater than MAX_DIM, go to SEND_ERR.
  - Otherwise latch the low 8 bits into the dimension registers for the selected matrix, set the element counter to 0, and go to DATA.
- DATA:
  - Each completed word drives mem_we=1 for exactly one cycle, the cycle after the 4th byte, with mem_addr = element counter.
  - The counter then increments.
  - After write rows*cols-1: set the selected valid flag and go to SEND_ACK. Valid is set in the same cycle as that final mem_we.
- SEND_ACK / SEND_ERR:
  - Wait for tx_busy == 0, then drive tx_data = 0x06 or 0xAA with tx_begin=1 for one cycle, then return to IDLE.
  - rx_ready pulses arriving in these states are dropped.
- Error abort: in HDR_ROWS, HDR_COLS or DATA, an rx_error pulse, or more than TIMEOUT_CYCLES clocks without rx_ready, goes to SEND_ERR.
  - The selected matrix's valid flag stays 0.
  - Elements already written are left as-is.
  - rx_error in IDLE is ignored.
- Simultaneous events:
  - If rx_error and rx_ready occur in the same cycle, the byte is discarded and the abort is taken.
  - The timeout counter clears on every rx_ready.
- Latency:
  - 1 cycle from 4th-byte rx_ready to mem_we.
  - 1 cycle from command-byte rx_ready to cmd_multiply or cmd_tx_result.
  - tx_begin no earlier than 1 cycle after the final byte.

Decomposition:
- Package mma_pkg: command byte constants, state enumeration, MAX_DIM default.
- Sub-module mma_word_assembler: byte counter, shift register, word_valid pulse, and clear input for abort.
- The parser FSM, element counter and timeout counter stay in mma_matrix_rx.

Test Plan:
- Load 2x2 A: send 01, 00000002, 00000002, 3F800000, 40000000, 40400000, 40800000.
  - Expect writes mem_sel=0 at addr 0..3 with those words.
  - Expect rows_a=cols_a=2, a_valid=1, tx_data=06 with one tx_begin.
- Load 2x2 B (5f..8f: 40A00000, 40C00000, 40E00000, 41000000), then send 03.
  - Expect b_valid=1, ACK, then a single cmd_multiply pulse one cycle after the 03 byte.
- Send 03 with only A loaded, or with A 2x3 and B 2x2.
  - Expect tx_data=AA, no cmd_multiply.
- Send 01, rows=0x00000011 (17 > MAX_DIM).
  - Expect ERR, no mem_we, a_valid=0.
- Send 01, 2x2 header, 5 data bytes, then hold the line idle past TIMEOUT_CYCLES (bench overrides it to 100).
  - Expect exactly one mem_we (addr 0), then ERR, and a_valid still 0.
  - Next command 0x04 is accepted and cmd_tx_result pulses.
- Assert reset mid-DATA.
  - Expect all outputs 0 next cycle, no ERR sent.
  - A fresh 01 packet then loads correctly.
